// File: rtl/cdb_complete_buffer.sv
// Complete-stage buffer: in-order FIFO gathering FU results, broadcasting up to N_WAY tags per cycle.
// Latency: 2 edges from fu_valid to lanes. Backpressure: fu_ready drops when free space < N_FU; branch_haz flushes.
module cdb_complete_buffer #(
    parameter int N_WAY    = 2,
    parameter int N_FU     = 4,
    parameter int DEPTH    = 8,
    parameter int CDB_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [N_FU-1:0]                     fu_valid,
    input  logic [N_FU-1:0][CDB_BITS-1:0]       fu_tag,
    input  logic [N_FU-1:0]                     fu_take_branch,
    input  logic [N_FU-1:0][XLEN-1:0]           fu_br_result,
    output logic [N_FU-1:0]                     fu_ready,
    input  logic                                branch_haz,
    output logic [N_WAY-1:0][CDB_BITS-1:0]      complete_dest_tag,
    output logic [N_WAY-1:0]                    take_branch,
    output logic [N_WAY-1:0][XLEN-1:0]          br_result,
    output logic [$clog2(DEPTH):0]              occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] N_FU_C  = CW'(N_FU);
    localparam logic [CW-1:0] N_WAY_C = CW'(N_WAY);

    typedef struct packed {
        logic [CDB_BITS-1:0] tag;
        logic                tb;
        logic [XLEN-1:0]     br;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic            ready;
    logic [N_FU-1:0] acc;
    logic [PW-1:0]   slot [N_FU];
    logic [CW-1:0]   enq_cnt, deq_cnt;

    // Ready looks only at the registered count, so FUs never see a path through dequeue.
    assign ready     = (DEPTH_C - count) >= N_FU_C;
    assign fu_ready  = {N_FU{ready}};
    assign occupancy = count;
    assign deq_cnt   = (count < N_WAY_C) ? count : N_WAY_C;

    // Accepted results are packed densely from tail, lowest FU index first.
    always_comb begin
        enq_cnt = '0;
        acc     = '0;
        for (int i = 0; i < N_FU; i++) begin
            slot[i] = tail + enq_cnt[PW-1:0];
            if (fu_valid[i] && ready && (fu_tag[i] != '0)) begin
                acc[i]  = 1'b1;
                enq_cnt = enq_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!branch_haz) begin
            for (int i = 0; i < N_FU; i++) begin
                if (acc[i]) mem[slot[i]] <= '{tag: fu_tag[i], tb: fu_take_branch[i], br: fu_br_result[i]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            complete_dest_tag <= '0;
            take_branch       <= '0;
            br_result         <= '0;
        end else if (branch_haz) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            complete_dest_tag <= '0;
            take_branch       <= '0;
            br_result         <= '0;
        end else begin
            head  <= head + deq_cnt[PW-1:0];
            tail  <= tail + enq_cnt[PW-1:0];
            count <= count - deq_cnt + enq_cnt;
            for (int k = 0; k < N_WAY; k++) begin
                if (CW'(k) < deq_cnt) begin
                    complete_dest_tag[k] <= mem[head + PW'(k)].tag;
                    take_branch[k]       <= mem[head + PW'(k)].tb;
                    br_result[k]         <= mem[head + PW'(k)].br;
                end else begin
                    complete_dest_tag[k] <= '0;
                    take_branch[k]       <= 1'b0;
                    br_result[k]         <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_complete_buffer.sv
// Randomized bench for cdb_complete_buffer against a queue-based reference model.
module tb_cdb_complete_buffer;
    localparam int N_WAY = 2, N_FU = 4, DEPTH = 8, CDB_BITS = 6, XLEN = 32;

    logic                           clock = 1'b0;
    logic                           reset;
    logic [N_FU-1:0]                fu_valid;
    logic [N_FU-1:0][CDB_BITS-1:0]  fu_tag;
    logic [N_FU-1:0]                fu_take_branch;
    logic [N_FU-1:0][XLEN-1:0]      fu_br_result;
    logic [N_FU-1:0]                fu_ready;
    logic                           branch_haz;
    logic [N_WAY-1:0][CDB_BITS-1:0] complete_dest_tag;
    logic [N_WAY-1:0]               take_branch;
    logic [N_WAY-1:0][XLEN-1:0]     br_result;
    logic [3:0]                     occupancy;

    cdb_complete_buffer #(.N_WAY(N_WAY), .N_FU(N_FU), .DEPTH(DEPTH), .CDB_BITS(CDB_BITS), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_tag(fu_tag),
        .fu_take_branch(fu_take_branch), .fu_br_result(fu_br_result), .fu_ready(fu_ready),
        .branch_haz(branch_haz), .complete_dest_tag(complete_dest_tag), .take_branch(take_branch),
        .br_result(br_result), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CDB_BITS-1:0] tag;
        logic                tb;
        logic [XLEN-1:0]     br;
    } ent_t;

    ent_t                           mq[$];
    logic [N_WAY-1:0][CDB_BITS-1:0] exp_tag;
    logic [N_WAY-1:0]               exp_tb;
    logic [N_WAY-1:0][XLEN-1:0]     exp_br;
    logic [3:0]                     exp_occ;
    logic [N_FU-1:0]                exp_rdy, obs_rdy;
    int                             tests = 0, fails = 0;
    logic [CDB_BITS-1:0]            tag_ctr = 1;

    task automatic idle();
        fu_valid = '0; fu_tag = '0; fu_take_branch = '0; fu_br_result = '0; branch_haz = 1'b0;
    endtask

    task automatic drive_fu(input int i, input logic [CDB_BITS-1:0] t);
        fu_valid[i]       = 1'b1;
        fu_tag[i]         = t;
        fu_take_branch[i] = 1'($urandom_range(0, 1));
        fu_br_result[i]   = $urandom;
    endtask

    task automatic fresh_tag(output logic [CDB_BITS-1:0] t);
        t = tag_ctr;
        tag_ctr = (tag_ctr == 6'd63) ? 6'd1 : tag_ctr + 6'd1;
    endtask

    // Model: the buffer is a plain queue; each edge pops up to N_WAY, then pushes accepted nonzero tags.
    task automatic cycle();
        int n;
        ent_t e;
        obs_rdy = fu_ready;
        exp_rdy = ((DEPTH - mq.size()) >= N_FU) ? '1 : '0;
        exp_tag = '0; exp_tb = '0; exp_br = '0;
        if (branch_haz) mq.delete();
        else begin
            n = (mq.size() < N_WAY) ? mq.size() : N_WAY;
            for (int k = 0; k < n; k++) begin
                e = mq.pop_front();
                exp_tag[k] = e.tag; exp_tb[k] = e.tb; exp_br[k] = e.br;
            end
            if (exp_rdy[0]) begin
                for (int i = 0; i < N_FU; i++)
                    if (fu_valid[i] && fu_tag[i] != '0)
                        mq.push_back('{tag: fu_tag[i], tb: fu_take_branch[i], br: fu_br_result[i]});
            end
        end
        exp_occ = 4'(mq.size());
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        logic [CDB_BITS-1:0] t;
        tests++;
        if (complete_dest_tag !== '0 || take_branch !== '0 || br_result !== '0 || occupancy !== 4'd0 || fu_ready !== 4'b1111) begin
            fails++; $display("FAIL reset_init: tag=%h tb=%b br=%h occ=%0d rdy=%b, want zeros occ 0 rdy 1111",
                              complete_dest_tag, take_branch, br_result, occupancy, fu_ready);
        end
        idle();
        for (int i = 0; i < 4; i++) begin fresh_tag(t); drive_fu(i, t); end
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin fresh_tag(t); drive_fu(i, t); end
        cycle();
        idle();
        tests++;
        if (occupancy !== 4'd5 || complete_dest_tag !== exp_tag) begin
            fails++; $display("FAIL reset_prefill: occ=%0d tag=%h, want occ 5 tag=%h", occupancy, complete_dest_tag, exp_tag);
        end
        reset = 1'b0;
        #2;
        tests++;
        if (complete_dest_tag !== '0 || take_branch !== '0 || br_result !== '0 || occupancy !== 4'd0) begin
            fails++; $display("FAIL reset_async: tag=%h tb=%b br=%h occ=%0d, want all 0",
                              complete_dest_tag, take_branch, br_result, occupancy);
        end
        mq.delete();
        #1 reset = 1'b1;
        #1;
        tests++;
        if (fu_ready !== 4'b1111) begin
            fails++; $display("FAIL reset_ready: rdy=%b, want 1111", fu_ready);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_single();
        idle();
        drive_fu(2, 6'd9);
        fu_take_branch[2] = 1'b1;
        fu_br_result[2]   = 32'h100;
        for (int c = 0; c < 3; c++) begin
            cycle();
            idle();
            tests++;
            if (complete_dest_tag !== exp_tag || take_branch !== exp_tb || br_result !== exp_br || occupancy !== exp_occ || obs_rdy !== exp_rdy) begin
                fails++; $display("FAIL single c%0d: tag=%h tb=%b br=%h occ=%0d rdy=%b, want tag=%h tb=%b br=%h occ=%0d rdy=%b",
                                  c, complete_dest_tag, take_branch, br_result, occupancy, obs_rdy, exp_tag, exp_tb, exp_br, exp_occ, exp_rdy);
            end
            if (c == 1) begin
                tests++;
                if (complete_dest_tag[0] !== 6'd9 || complete_dest_tag[1] !== 6'd0 || take_branch[0] !== 1'b1 || br_result[0] !== 32'h100) begin
                    fails++; $display("FAIL single_lane0: tag0=%0d tag1=%0d tb0=%b br0=%h, want 9 0 1 00000100",
                                      complete_dest_tag[0], complete_dest_tag[1], take_branch[0], br_result[0]);
                end
            end
        end
    endtask

    task automatic test_burst();
        logic [CDB_BITS-1:0] want [4][2];
        want[0] = '{6'd0, 6'd0}; want[1] = '{6'd3, 6'd4}; want[2] = '{6'd5, 6'd6}; want[3] = '{6'd0, 6'd0};
        idle();
        for (int i = 0; i < 4; i++) drive_fu(i, 6'(3 + i));
        for (int c = 0; c < 4; c++) begin
            cycle();
            idle();
            tests++;
            if (complete_dest_tag !== exp_tag || take_branch !== exp_tb || br_result !== exp_br || occupancy !== exp_occ || obs_rdy !== exp_rdy) begin
                fails++; $display("FAIL burst c%0d: tag=%h tb=%b br=%h occ=%0d rdy=%b, want tag=%h tb=%b br=%h occ=%0d rdy=%b",
                                  c, complete_dest_tag, take_branch, br_result, occupancy, obs_rdy, exp_tag, exp_tb, exp_br, exp_occ, exp_rdy);
            end
            tests++;
            if (complete_dest_tag[0] !== want[c][0] || complete_dest_tag[1] !== want[c][1]) begin
                fails++; $display("FAIL burst_order c%0d: lanes=(%0d,%0d), want (%0d,%0d)",
                                  c, complete_dest_tag[0], complete_dest_tag[1], want[c][0], want[c][1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [CDB_BITS-1:0] t;
        int peak = 0;
        idle();
        exp_rdy = '1;
        for (int c = 0; c < 24; c++) begin
            if (c < 20) begin
                if (exp_rdy[0]) for (int i = 0; i < 4; i++) begin fresh_tag(t); drive_fu(i, t); end
            end else idle();
            cycle();
            if (int'(occupancy) > peak) peak = int'(occupancy);
            tests++;
            if (complete_dest_tag !== exp_tag || take_branch !== exp_tb || br_result !== exp_br || occupancy !== exp_occ || obs_rdy !== exp_rdy) begin
                fails++; $display("FAIL backpressure c%0d: tag=%h tb=%b br=%h occ=%0d rdy=%b, want tag=%h tb=%b br=%h occ=%0d rdy=%b",
                                  c, complete_dest_tag, take_branch, br_result, occupancy, obs_rdy, exp_tag, exp_tb, exp_br, exp_occ, exp_rdy);
            end
        end
        tests++;
        if (peak != 6) begin
            fails++; $display("FAIL backpressure_peak: peak occ=%0d, want 6", peak);
        end
    endtask

    task automatic test_flush();
        logic [CDB_BITS-1:0] t;
        for (int c = 0; c < 9; c++) begin
            idle();
            if (c < 2) for (int i = 0; i < 4; i++) begin fresh_tag(t); drive_fu(i, t); end
            if (c == 2) begin
                for (int i = 0; i < 2; i++) begin fresh_tag(t); drive_fu(i, t); end
                branch_haz = 1'b1;
                tests++;
                if (occupancy !== 4'd6) begin
                    fails++; $display("FAIL flush_prefill: occ=%0d, want 6", occupancy);
                end
            end
            cycle();
            tests++;
            if (complete_dest_tag !== exp_tag || take_branch !== exp_tb || br_result !== exp_br || occupancy !== exp_occ || obs_rdy !== exp_rdy) begin
                fails++; $display("FAIL flush c%0d: tag=%h tb=%b br=%h occ=%0d rdy=%b, want tag=%h tb=%b br=%h occ=%0d rdy=%b",
                                  c, complete_dest_tag, take_branch, br_result, occupancy, obs_rdy, exp_tag, exp_tb, exp_br, exp_occ, exp_rdy);
            end
            if (c >= 2) begin
                tests++;
                if (complete_dest_tag !== '0 || occupancy !== 4'd0) begin
                    fails++; $display("FAIL flush_empty c%0d: tag=%h occ=%0d, want 0 0", c, complete_dest_tag, occupancy);
                end
            end
        end
    endtask

    task automatic test_wrap_tag0();
        logic [CDB_BITS-1:0] t;
        for (int c = 0; c < 26; c++) begin
            idle();
            if (c < 20) begin
                fresh_tag(t);
                if ($urandom_range(0, 3) == 0) t = '0;
                drive_fu($urandom_range(0, N_FU - 1), t);
            end
            cycle();
            tests++;
            if (complete_dest_tag !== exp_tag || take_branch !== exp_tb || br_result !== exp_br || occupancy !== exp_occ || obs_rdy !== exp_rdy) begin
                fails++; $display("FAIL wrap c%0d: tag=%h tb=%b br=%h occ=%0d rdy=%b, want tag=%h tb=%b br=%h occ=%0d rdy=%b",
                                  c, complete_dest_tag, take_branch, br_result, occupancy, obs_rdy, exp_tag, exp_tb, exp_br, exp_occ, exp_rdy);
            end
        end
    endtask

    task automatic test_random();
        logic [CDB_BITS-1:0] t;
        for (int c = 0; c < 300; c++) begin
            idle();
            if (c < 290) begin
                for (int i = 0; i < N_FU; i++) begin
                    if ($urandom_range(0, 2) != 0) begin
                        fresh_tag(t);
                        if ($urandom_range(0, 7) == 0) t = '0;
                        drive_fu(i, t);
                    end
                end
                branch_haz = ($urandom_range(0, 24) == 0);
            end
            cycle();
            tests++;
            if (complete_dest_tag !== exp_tag || take_branch !== exp_tb || br_result !== exp_br || occupancy !== exp_occ || obs_rdy !== exp_rdy) begin
                fails++; $display("FAIL random c%0d: tag=%h tb=%b br=%h occ=%0d rdy=%b, want tag=%h tb=%b br=%h occ=%0d rdy=%b",
                                  c, complete_dest_tag, take_branch, br_result, occupancy, obs_rdy, exp_tag, exp_tb, exp_br, exp_occ, exp_rdy);
            end
        end
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #12 reset = 1'b1;
        @(posedge clock); #1;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_flush();
        test_wrap_tag0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
